// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// accum_pkg - default widths and record types for the accumulator bank front end
// rev 1.0
// ============================================================================
package accum_pkg;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 64;

  // Record widths follow the package defaults; instances use matching widths.
  typedef struct packed {
    logic                      valid;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_NUM_BANKS-1:0]  mask;
  } sb_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [DEF_NUM_BANKS-1:0] mask;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/accum_rd_fifo.sv
`default_nettype none
// ============================================================================
// accum_rd_fifo - first-word-fall-through FIFO for read returns
// rev 1.0
// ============================================================================
module accum_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the output is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/accum_bank_ctrl.sv
`default_nettype none
// ============================================================================
// accum_bank_ctrl - accumulator bus to per-bank RAM strobes, with hazard stalls
// rev 1.0
// ============================================================================
module accum_bank_ctrl
  import accum_pkg::*;
#(
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_LATENCY  = 1,
  parameter int ACC_LATENCY = 2,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [NUM_BANKS-1:0]                wr_mask,
  input  logic                                wr_accum,
  input  logic                                wvalid,
  output logic                                wready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]     wdata,
  input  logic                                rd_valid,
  output logic                                rd_ready,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  input  logic [NUM_BANKS-1:0]                rd_mask,
  output logic                                rvalid,
  input  logic                                rready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]     rdata,
  output logic [NUM_BANKS-1:0]                rmask,
  output logic [NUM_BANKS-1:0]                bank_wr_en,
  output logic [ADDR_WIDTH-1:0]               bank_wr_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]     bank_wr_data,
  output logic                                bank_mode,
  output logic [NUM_BANKS-1:0]                bank_rd_en,
  output logic [ADDR_WIDTH-1:0]               bank_rd_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]     bank_rd_data,
  output logic [$clog2(RFIFO_DEPTH+1)-1:0]    rd_outstanding,
  output logic                                hazard_stall
);

  localparam int CNT_W  = $clog2(RFIFO_DEPTH+1);
  localparam int LANE_W = NUM_BANKS*DATA_WIDTH;
  localparam int FIFO_W = LANE_W + NUM_BANKS;

  sb_entry_t             sb_q  [ACC_LATENCY];
  sb_entry_t             sb_d  [ACC_LATENCY];
  rd_tag_t               tag_q [RD_LATENCY];
  rd_tag_t               tag_d [RD_LATENCY];
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;

  logic                  wr_fire, rd_fire, pop, hazard, credit_ok;
  logic                  ret_push;
  logic [LANE_W-1:0]     ret_data;
  logic [FIFO_W-1:0]     fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  // Handshake outputs are held low while reset is asserted.
  assign wr_ready = rstn & wvalid;
  assign wready   = rstn & wr_valid;
  assign wr_fire  = rstn & wr_valid & wvalid;

  assign bank_wr_en   = wr_fire ? wr_mask : '0;
  assign bank_wr_addr = wr_addr;
  assign bank_wr_data = wdata;
  assign bank_mode    = wr_fire & wr_accum;

  // A same-cycle write to the same word/lane also blocks the read.
  always_comb begin
    hazard = wr_fire && (wr_addr == rd_addr) && |(wr_mask & rd_mask);
    for (int i = 0; i < ACC_LATENCY; i++) begin
      if (sb_q[i].valid && (sb_q[i].addr == rd_addr) && |(sb_q[i].mask & rd_mask))
        hazard = 1'b1;
    end
  end

  assign rvalid       = !fifo_empty;
  assign pop          = rvalid & rready;
  assign credit_ok    = (outstanding_q < CNT_W'(RFIFO_DEPTH)) || pop;
  assign rd_ready     = rstn & ~hazard & credit_ok;
  assign rd_fire      = rd_valid & rd_ready;
  assign hazard_stall = rstn & rd_valid & hazard;
  assign bank_rd_en   = rd_fire ? rd_mask : '0;
  assign bank_rd_addr = rd_addr;

  always_comb begin
    sb_d[0] = '{valid: wr_fire, addr: wr_addr, mask: wr_mask};
    for (int i = 1; i < ACC_LATENCY; i++) sb_d[i] = sb_q[i-1];
    tag_d[0] = '{valid: rd_fire, mask: rd_mask};
    for (int i = 1; i < RD_LATENCY; i++) tag_d[i] = tag_q[i-1];
    outstanding_d = outstanding_q + CNT_W'(rd_fire) - CNT_W'(pop);
  end

  always_comb begin
    ret_push = tag_q[RD_LATENCY-1].valid;
    for (int i = 0; i < NUM_BANKS; i++)
      ret_data[i*DATA_WIDTH +: DATA_WIDTH] = tag_q[RD_LATENCY-1].mask[i]
          ? bank_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ACC_LATENCY; i++) sb_q[i]  <= '0;
      for (int i = 0; i < RD_LATENCY; i++)  tag_q[i] <= '0;
      outstanding_q <= '0;
    end else begin
      for (int i = 0; i < ACC_LATENCY; i++) sb_q[i]  <= sb_d[i];
      for (int i = 0; i < RD_LATENCY; i++)  tag_q[i] <= tag_d[i];
      outstanding_q <= outstanding_d;
    end
  end

  accum_rd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RFIFO_DEPTH)
  ) u_rd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ret_push),
    .din   ({tag_q[RD_LATENCY-1].mask, ret_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rdata          = fifo_dout[LANE_W-1:0];
  assign rmask          = fifo_dout[LANE_W +: NUM_BANKS];
  assign rd_outstanding = outstanding_q;

  // Credits bound FIFO occupancy, so neither property may ever fire.
  assert property (@(posedge clk) disable iff (!rstn) !(ret_push && fifo_full && !pop))
    else $error("read-return FIFO overflow");
  assert property (@(posedge clk) disable iff (!rstn) outstanding_q >= fifo_count)
    else $error("credit count below FIFO occupancy");

endmodule
`default_nettype wire

// File: tb/tb_accum_bank_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_accum_bank_ctrl - randomized bench with a transaction-level reference model
// rev 1.0
// ============================================================================
module tb_accum_bank_ctrl;

  localparam int NB    = 4;
  localparam int AW    = 9;
  localparam int DW    = 64;
  localparam int RDL   = 1;
  localparam int ACCL  = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int LW    = NB*DW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid, wvalid, wr_accum, rd_valid, rready;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [NB-1:0] wr_mask, rd_mask;
  logic [LW-1:0] wdata;

  logic          wr_ready, wready, rd_ready, rvalid, bank_mode, hazard_stall;
  logic [LW-1:0] rdata, bank_wr_data, bank_rd_data;
  logic [NB-1:0] rmask, bank_wr_en, bank_rd_en;
  logic [AW-1:0] bank_wr_addr, bank_rd_addr;
  logic [CW-1:0] rd_outstanding;

  accum_bank_ctrl #(
    .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RD_LATENCY(RDL), .ACC_LATENCY(ACCL), .RFIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wr_accum(wr_accum), .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_mask(rd_mask),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rmask(rmask),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_data(bank_wr_data),
    .bank_mode(bank_mode), .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
    .bank_rd_data(bank_rd_data), .rd_outstanding(rd_outstanding),
    .hazard_stall(hazard_stall)
  );

  // ---------------- bank RAM model: contents are a fixed function of address
  logic use_hash = 1'b0;
  int   cyc = 0;
  logic [LW-1:0] ram_pipe [RDL];

  function automatic logic [DW-1:0] ram_word(int lane, logic [AW-1:0] a, logic h);
    logic [31:0] lo;
    lo = 32'(a) * 32'h9E3779B1;
    if (h) return {8'(lane), 8'hA5, 7'd0, a, lo};
    return DW'(10 + lane);
  endfunction

  // Disabled lanes return junk so the zeroing of unmasked lanes is exercised.
  function automatic logic [LW-1:0] ram_line(logic [NB-1:0] en, logic [AW-1:0] a, logic h);
    logic [LW-1:0] v;
    for (int i = 0; i < NB; i++)
      v[i*DW +: DW] = en[i] ? ram_word(i, a, h) : {$urandom, $urandom};
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_pipe[0] <= ram_line(bank_rd_en, bank_rd_addr, use_hash);
    for (int i = 1; i < RDL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bank_rd_data = ram_pipe[RDL-1];

  // ---------------- reference model: transaction queues with cycle stamps
  typedef struct { int avail; logic [LW-1:0] data; logic [NB-1:0] mask; } ret_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [NB-1:0] mask; } wr_t;
  ret_t rq[$];
  wr_t  wh[$];

  logic          exp_wr_ready, exp_wready, exp_bank_mode, exp_rd_ready, exp_hazard, exp_rvalid;
  logic [NB-1:0] exp_bank_wr_en, exp_bank_rd_en, exp_rmask;
  logic [LW-1:0] exp_rdata;
  int            exp_outst;
  logic          m_wfire, m_rfire, m_pop;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    rq.delete();
    wh.delete();
  endtask

  task automatic cycle_begin();
    @(negedge clk);
    wr_valid = 0; wvalid = 0; wr_accum = 0; wr_addr = '0; wr_mask = '0; wdata = '0;
    rd_valid = 0; rd_addr = '0; rd_mask = '0; rready = 0;
  endtask

  // Let combinational outputs settle, then derive every expected output.
  task automatic settle();
    logic blocked;
    #1;
    m_wfire = wr_valid && wvalid;
    blocked = m_wfire && (wr_addr == rd_addr) && |(wr_mask & rd_mask);
    foreach (wh[i])
      if (cyc - wh[i].cyc <= ACCL && wh[i].addr == rd_addr && |(wh[i].mask & rd_mask))
        blocked = 1'b1;
    exp_rvalid     = (rq.size() > 0) && (rq[0].avail <= cyc);
    m_pop          = exp_rvalid && rready;
    exp_outst      = rq.size();
    exp_rd_ready   = !blocked && (rq.size() - int'(m_pop) < DEPTH);
    exp_hazard     = rd_valid && blocked;
    m_rfire        = rd_valid && exp_rd_ready;
    exp_bank_rd_en = m_rfire ? rd_mask : '0;
    exp_rdata      = exp_rvalid ? rq[0].data : '0;
    exp_rmask      = exp_rvalid ? rq[0].mask : '0;
    exp_bank_wr_en = m_wfire ? wr_mask : '0;
    exp_bank_mode  = m_wfire && wr_accum;
    exp_wr_ready   = wvalid;
    exp_wready     = wr_valid;
  endtask

  task automatic tick();
    ret_t r;
    wr_t  w;
    if (m_pop) void'(rq.pop_front());
    if (m_rfire) begin
      r.avail = cyc + RDL + 1;
      r.mask  = rd_mask;
      for (int i = 0; i < NB; i++)
        r.data[i*DW +: DW] = rd_mask[i] ? ram_word(i, rd_addr, use_hash) : '0;
      rq.push_back(r);
    end
    if (m_wfire) begin
      w.cyc = cyc; w.addr = wr_addr; w.mask = wr_mask;
      wh.push_back(w);
    end
    while (wh.size() > 0 && (cyc + 1 - wh[0].cyc) > ACCL) void'(wh.pop_front());
    @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (rq.size() > 0 && guard < 40) begin
      cycle_begin(); rready = 1; settle();
      n_checks++;
      if (rvalid !== exp_rvalid) begin
        n_fail++; $display("FAIL %s drain rvalid: got %b expected %b", tag, rvalid, exp_rvalid);
      end
      if (exp_rvalid) begin
        n_checks++;
        if (rdata !== exp_rdata || rmask !== exp_rmask) begin
          n_fail++; $display("FAIL %s drain rdata: got %h/%b expected %h/%b", tag, rdata, rmask, exp_rdata, exp_rmask);
        end
      end
      tick(); guard++;
    end
    cycle_begin(); settle();
    n_checks++;
    if (rd_outstanding !== CW'(0) || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL %s drain end: outstanding %0d rvalid %b expected 0 0", tag, rd_outstanding, rvalid);
    end
    tick();
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    cycle_begin();
    rstn = 0; model_reset();
    wr_valid = 1; wvalid = 1; rd_valid = 1; rd_mask = 4'hF; wr_mask = 4'hF; wr_accum = 1; rready = 1;
    #1;
    n_checks++;
    if ({wr_ready, wready, rd_ready, rvalid, bank_mode, hazard_stall} !== 6'b0) begin
      n_fail++; $display("FAIL reset handshakes: got %b expected 000000",
                         {wr_ready, wready, rd_ready, rvalid, bank_mode, hazard_stall});
    end
    n_checks++;
    if (bank_wr_en !== '0 || bank_rd_en !== '0 || rd_outstanding !== '0) begin
      n_fail++; $display("FAIL reset strobes: wr_en %b rd_en %b outst %0d expected 0", bank_wr_en, bank_rd_en, rd_outstanding);
    end
    n_checks++;
    if (rdata !== '0 || rmask !== '0) begin
      n_fail++; $display("FAIL reset rdata: got %h/%b expected 0", rdata, rmask);
    end
    repeat (2) @(posedge clk);
    cycle_begin();
    rstn = 1;
    settle();
    n_checks++;
    if (rd_ready !== 1'b1 || rd_ready !== exp_rd_ready) begin
      n_fail++; $display("FAIL reset first cycle rd_ready: got %b expected 1", rd_ready);
    end
    tick();
  endtask

  task automatic test_write_hazard();
    int stalls = 0;
    int fired_at = -1;
    cycle_begin();
    wr_valid = 1; wvalid = 1; wr_addr = 9'h010; wr_mask = 4'b0101; wr_accum = 1;
    wdata = {4{64'h1234_5678_9ABC_DEF0}};
    settle();
    n_checks++;
    if (bank_wr_en !== 4'b0101 || bank_mode !== 1'b1 || bank_wr_addr !== 9'h010 || bank_wr_data !== wdata) begin
      n_fail++; $display("FAIL write strobe: en %b mode %b addr %h expected 0101 1 010", bank_wr_en, bank_mode, bank_wr_addr);
    end
    n_checks++;
    if (wr_ready !== 1'b1 || wready !== 1'b1) begin
      n_fail++; $display("FAIL write ready: got %b %b expected 1 1", wr_ready, wready);
    end
    tick();
    for (int k = 1; k <= 10 && fired_at < 0; k++) begin
      cycle_begin();
      rd_valid = 1; rd_addr = 9'h010; rd_mask = 4'b0001; rready = 1;
      settle();
      n_checks++;
      if (hazard_stall !== exp_hazard || rd_ready !== exp_rd_ready) begin
        n_fail++; $display("FAIL hazard k=%0d: stall %b ready %b expected %b %b", k, hazard_stall, rd_ready, exp_hazard, exp_rd_ready);
      end
      if (hazard_stall) stalls++;
      if (rd_ready) fired_at = k;
      tick();
    end
    n_checks++;
    if (stalls !== ACCL || fired_at !== ACCL + 1) begin
      n_fail++; $display("FAIL hazard timing: stalls %0d fire offset %0d expected %0d %0d", stalls, fired_at, ACCL, ACCL + 1);
    end
    drain("hazard");
  endtask

  task automatic test_read_return();
    int seen = -1;
    use_hash = 0;
    cycle_begin();
    rd_valid = 1; rd_addr = 9'h010; rd_mask = 4'b0110; rready = 1;
    settle();
    n_checks++;
    if (rd_ready !== 1'b1 || bank_rd_en !== 4'b0110 || bank_rd_addr !== 9'h010) begin
      n_fail++; $display("FAIL read issue: ready %b en %b addr %h expected 1 0110 010", rd_ready, bank_rd_en, bank_rd_addr);
    end
    tick();
    for (int k = 1; k <= 6 && seen < 0; k++) begin
      cycle_begin(); rready = 1; settle();
      if (rvalid) begin
        seen = k;
        n_checks++;
        if (rdata !== {64'h0, 64'hC, 64'hB, 64'h0} || rmask !== 4'b0110) begin
          n_fail++; $display("FAIL read data: got %h/%b expected 0,C,B,0/0110", rdata, rmask);
        end
      end
      tick();
    end
    n_checks++;
    if (seen !== RDL + 1) begin
      n_fail++; $display("FAIL read latency: got %0d expected %0d", seen, RDL + 1);
    end
    drain("read");
  endtask

  task automatic test_credit();
    int fires = 0;
    use_hash = 1;
    for (int k = 0; k < 6; k++) begin
      cycle_begin();
      rd_valid = 1; rd_addr = AW'(9'h020 + k); rd_mask = NB'($urandom_range(0, 15));
      settle();
      n_checks++;
      if (rd_ready !== exp_rd_ready) begin
        n_fail++; $display("FAIL credit k=%0d rd_ready: got %b expected %b", k, rd_ready, exp_rd_ready);
      end
      if (rd_valid && rd_ready) fires++;
      tick();
    end
    cycle_begin();
    rd_valid = 1; rd_addr = 9'h030; rd_mask = 4'b1111;
    settle();
    n_checks++;
    if (fires !== DEPTH || rd_outstanding !== CW'(DEPTH) || rd_ready !== 1'b0) begin
      n_fail++; $display("FAIL credit full: fires %0d outst %0d ready %b expected %0d %0d 0", fires, rd_outstanding, rd_ready, DEPTH, DEPTH);
    end
    tick();
    cycle_begin();
    rd_valid = 1; rd_addr = 9'h031; rd_mask = 4'b1010; rready = 1;
    settle();
    n_checks++;
    if (rvalid !== 1'b1 || rd_ready !== 1'b1 || rdata !== exp_rdata) begin
      n_fail++; $display("FAIL credit pulse: rvalid %b ready %b expected 1 1", rvalid, rd_ready);
    end
    tick();
    cycle_begin(); settle();
    n_checks++;
    if (rd_outstanding !== CW'(DEPTH) || rd_ready !== 1'b0) begin
      n_fail++; $display("FAIL credit after pulse: outst %0d ready %b expected %0d 0", rd_outstanding, rd_ready, DEPTH);
    end
    tick();
    drain("credit");
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    use_hash = 1;
    for (int k = 0; k < 16 + 6; k++) begin
      cycle_begin();
      rready = 1;
      if (k < 16) begin
        rd_valid = 1; rd_addr = AW'($urandom_range(0, 511)); rd_mask = NB'($urandom_range(0, 15));
      end
      settle();
      n_checks++;
      if (rd_ready !== 1'b1 || hazard_stall !== 1'b0 || rvalid !== exp_rvalid) begin
        n_fail++; $display("FAIL b2b k=%0d: ready %b stall %b rvalid %b expected 1 0 %b", k, rd_ready, hazard_stall, rvalid, exp_rvalid);
      end
      if (rvalid) begin
        pops++;
        n_checks++;
        if (rdata !== exp_rdata || rmask !== exp_rmask) begin
          n_fail++; $display("FAIL b2b k=%0d data: got %h/%b expected %h/%b", k, rdata, rmask, exp_rdata, exp_rmask);
        end
        if (k >= RDL + 1 && k < 16 + RDL + 1 && !exp_rvalid) n_fail++;
      end
      tick();
    end
    n_checks++;
    if (pops !== 16) begin
      n_fail++; $display("FAIL b2b return count: got %0d expected 16", pops);
    end
  endtask

  task automatic test_random();
    use_hash = 1;
    for (int k = 0; k < 400; k++) begin
      cycle_begin();
      wr_valid = ($urandom_range(0, 9) < 4);
      wvalid   = ($urandom_range(0, 9) < 6);
      wr_addr  = AW'($urandom_range(0, 3));
      wr_mask  = NB'($urandom_range(0, 15));
      wr_accum = 1'($urandom);
      for (int i = 0; i < LW / 32; i++) wdata[i*32 +: 32] = $urandom;
      rd_valid = ($urandom_range(0, 9) < 6);
      rd_addr  = AW'($urandom_range(0, 3));
      rd_mask  = NB'($urandom_range(0, 15));
      rready   = ($urandom_range(0, 9) < 7);
      settle();
      n_checks++;
      if (wr_ready !== exp_wr_ready || wready !== exp_wready || bank_wr_en !== exp_bank_wr_en || bank_mode !== exp_bank_mode) begin
        n_fail++; $display("FAIL rand k=%0d write side: %b %b %b %b expected %b %b %b %b", k, wr_ready, wready, bank_wr_en,
                           bank_mode, exp_wr_ready, exp_wready, exp_bank_wr_en, exp_bank_mode);
      end
      n_checks++;
      if (rd_ready !== exp_rd_ready || hazard_stall !== exp_hazard || bank_rd_en !== exp_bank_rd_en) begin
        n_fail++; $display("FAIL rand k=%0d read issue: %b %b %b expected %b %b %b", k, rd_ready, hazard_stall, bank_rd_en,
                           exp_rd_ready, exp_hazard, exp_bank_rd_en);
      end
      n_checks++;
      if (rvalid !== exp_rvalid || rd_outstanding !== CW'(exp_outst)) begin
        n_fail++; $display("FAIL rand k=%0d return state: rvalid %b outst %0d expected %b %0d", k, rvalid, rd_outstanding, exp_rvalid, exp_outst);
      end
      if (exp_rvalid) begin
        n_checks++;
        if (rdata !== exp_rdata || rmask !== exp_rmask) begin
          n_fail++; $display("FAIL rand k=%0d rdata: got %h/%b expected %h/%b", k, rdata, rmask, exp_rdata, exp_rmask);
        end
      end
      tick();
    end
    drain("random");
  endtask

  task automatic test_reset_midflight();
    use_hash = 1;
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      rd_valid = 1; rd_addr = AW'(9'h040 + k); rd_mask = 4'b1111;
      settle();
      tick();
    end
    cycle_begin();
    rstn = 0; model_reset();
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || rd_outstanding !== '0) begin
      n_fail++; $display("FAIL midreset: rvalid %b outst %0d expected 0 0", rvalid, rd_outstanding);
    end
    repeat (2) @(posedge clk);
    cycle_begin();
    rstn = 1;
    settle();
    tick();
    for (int k = 0; k < 6; k++) begin
      cycle_begin(); rready = 1; settle();
      n_checks++;
      if (rvalid !== 1'b0 || rd_outstanding !== '0 || rd_ready !== 1'b1) begin
        n_fail++; $display("FAIL post-reset k=%0d: rvalid %b outst %0d ready %b expected 0 0 1", k, rvalid, rd_outstanding, rd_ready);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_hazard();
    test_read_return();
    test_credit();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/accum_bank_ctrl.md
# accum_bank_ctrl

Multi-bank front end for the accumulator group that replaces the fixed always-ready bus adapter. It converts the accumulator bus write, read and return channels into per-bank RAM-port strobes. It adds real backpressure, configurable RAM read latency, a credit-limited read-return FIFO, and read-after-accumulate hazard stalls. It sits between the accumulator bus and the accumulator group, one instance per group.

## Interface
Parameters:
- NUM_BANKS, 4, bank/lane count; write and read data are NUM_BANKS lanes
- ADDR_WIDTH, 9, bank word address width
- DATA_WIDTH, 64, per-lane data width
- RD_LATENCY, 1, bank read latency in cycles (1..4)
- ACC_LATENCY, 2, cycles until an accumulate/write is visible to a bank read (1..4)
- RFIFO_DEPTH, 4, read-return FIFO entries (power of 2, at least RD_LATENCY+1)

Ports:
- clk, in, 1, clock
- rstn, in, 1, asynchronous active-low reset
- wr_valid / wr_ready, in/out, 1, write command handshake
- wr_addr, in, ADDR_WIDTH, write address, broadcast to all banks
- wr_mask, in, NUM_BANKS, lanes to write
- wr_accum, in, 1, 1 = accumulate, 0 = overwrite
- wvalid / wready, in/out, 1, write data handshake
- wdata, in, NUM_BANKS*DATA_WIDTH, lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- rd_valid / rd_ready, in/out, 1, read command handshake
- rd_addr, in, ADDR_WIDTH; rd_mask, in, NUM_BANKS
- rvalid / rready, out/in, 1, read return handshake
- rdata, out, NUM_BANKS*DATA_WIDTH, returned lanes; unmasked lanes are zero
- rmask, out, NUM_BANKS, echo of the rd_mask for that read
- bank_wr_en, out, NUM_BANKS; bank_wr_addr, out, ADDR_WIDTH; bank_wr_data, out, NUM_BANKS*DATA_WIDTH
- bank_mode, out, 1, accumulate mode for the current write
- bank_rd_en, out, NUM_BANKS; bank_rd_addr, out, ADDR_WIDTH
- bank_rd_data, in, NUM_BANKS*DATA_WIDTH
- rd_outstanding, out, $clog2(RFIFO_DEPTH+1), count of in-flight reads plus FIFO occupancy
- hazard_stall, out, 1, high in any cycle in which a read is blocked by the scoreboard

## Operation

Write channel:
- A write fires in a cycle when wr_valid and wvalid are both high.
- wr_ready = wvalid and wready = wr_valid. The write side never stalls.
- In the firing cycle the block drives, combinationally: bank_wr_en = wr_mask, bank_wr_addr = wr_addr, bank_wr_data = wdata, bank_mode = wr_accum.
- When no write fires, bank_wr_en is 0 and bank_mode is 0.

Hazard scoreboard:
- Shift register of ACC_LATENCY entries {valid, addr, mask}. Each firing write is pushed into it.
- A read is blocked when rd_addr equals an entry's address and rd_mask overlaps that entry's mask.
- The check covers every valid scoreboard entry and the write firing in the same cycle. A concurrent write to the same address and lane therefore wins, and the read waits.

Read issue:
- rd_ready = no hazard AND (rd_outstanding + inflight_this_cycle < RFIFO_DEPTH). This is a credit check.
- A read fires when rd_valid and rd_ready are both high. In that cycle bank_rd_en = rd_mask and bank_rd_addr = rd_addr.
- A read with rd_mask = 0 still consumes a credit and returns zeros.
- A RD_LATENCY-deep tag pipeline {valid, mask} tracks issued reads.

Return path:
- When the tag pipeline output is valid, bank_rd_data is pushed into the FIFO with unmasked lanes zeroed, along with the mask.
- The FIFO is first-word-fall-through: rvalid = !empty. A pop occurs when rvalid and rready are both high.
- The FIFO never overflows by construction. An overflow is an assertion failure.
- rd_outstanding increments on read fire and decrements on pop. Both in the same cycle leaves it unchanged.

## Timing
- Reset values: wr_ready 0, wready 0, rd_ready 0, rvalid 0, rdata 0, rmask 0, bank_wr_en 0, bank_rd_en 0, bank_mode 0, rd_outstanding 0, hazard_stall 0. The scoreboard, tag pipeline and FIFO are all cleared.
- Write: strobes appear in the same cycle as the handshake (0-cycle latency).
- Read fired in cycle t:
  - bank_rd_en is high in cycle t.
  - bank_rd_data is sampled at the end of cycle t+RD_LATENCY.
  - rvalid rises in cycle t+RD_LATENCY+1 if the FIFO was empty. Minimum latency is RD_LATENCY+1.
- Write fired in cycle t blocks same-address, overlapping-lane reads in cycles t through t+ACC_LATENCY. The earliest matching read issues in cycle t+ACC_LATENCY+1.
- Back-to-back reads sustain 1 per cycle when rready is held high and RFIFO_DEPTH ≥ RD_LATENCY+1.
- Once the FIFO holds RFIFO_DEPTH entries (including in-flight reads), rd_ready is low until the next pop. rd_ready may rise in the same cycle as the pop.
- Reset mid-operation drops all in-flight reads and pending returns. The first post-reset cycle behaves as idle.

## Structure
- Package accum_pkg holds:
  - default constants: NUM_BANKS, ADDR_WIDTH, DATA_WIDTH;
  - typedef sb_entry_t {valid, addr, mask};
  - typedef rd_tag_t {valid, mask}.
- Sub-module accum_rd_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, async active-low reset.
- The scoreboard and tag pipeline stay inline in accum_bank_ctrl.

## Test plan
- Reset, then idle → all outputs at reset values; rd_ready is 1 in the first cycle after rstn deasserts.
- Write addr 0x10, mask 4'b0101, wr_accum=1 → bank_wr_en = 4'b0101 and bank_mode = 1 in the same cycle.
  - Read of 0x10, mask 4'b0001, presented in the next cycle → hazard_stall high for ACC_LATENCY cycles; the read fires in cycle t+3 (defaults).
- Read addr 0x10 mask 4'b0110 with bank_rd_data lanes = 0xA,0xB,0xC,0xD → rvalid 2 cycles after the fire; rdata lanes = 0,0xB,0xC,0; rmask = 4'b0110.
- rready held 0 while 6 reads are presented → exactly 4 fire; rd_outstanding = 4 and rd_ready = 0.
  - Then pulse rready for one cycle → one pop and one new read fire.
- 16 back-to-back reads with rready = 1 → 16 returns in issue order at 1 per cycle; no hazard_stall.
- Assert rstn low while 3 reads are in flight → rvalid = 0, rd_outstanding = 0, and no stale return after reset release.
